// File: rtl/if_fetch_stage.sv
// MIPS32 instruction-fetch stage: PC register, single-outstanding imem request,
// one-entry response buffer for words returned while the pipeline is held.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// FETCH    | request outstanding for PC; result goes to IF/ID or the buffer
// BUFFERED | response captured while held; no request until it is consumed
// DISCARD  | request for stale_addr still in flight after a redirect; drop it
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               HoldPC,
  input  logic               IF_ID_Hold_Data,
  input  logic               redirect_en,
  input  logic [31:0]        redirect_pc,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [31:0]        PC,
  output logic [INSTR_W-1:0] IF_ID_Instr,
  output logic [31:0]        IF_ID_PC_plus4,
  output logic               IF_ID_Valid
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_BUFFERED = 2'd1,
    S_DISCARD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        stale_q, stale_d;
  logic [INSTR_W-1:0] buf_q, buf_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic               hold;
  logic               bubble;
  logic [31:0]        pc_plus4;
  logic [31:0]        redir_tgt;

  assign hold      = HoldPC | IF_ID_Hold_Data;
  assign pc_plus4  = pc_q + 32'd4;
  assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stale_d = stale_q;
    buf_d   = buf_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    bubble  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect_en) begin
          pc_d   = redir_tgt;
          bubble = 1'b1;
          if (!imem_valid) begin
            stale_d = pc_q;
            state_d = S_DISCARD;
          end
        end else if (hold) begin
          if (imem_valid) begin
            buf_d   = imem_rdata;
            state_d = S_BUFFERED;
          end
        end else if (imem_valid) begin
          instr_d = imem_rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end else begin
          bubble = 1'b1;
        end
      end
      S_BUFFERED: begin
        if (redirect_en) begin
          pc_d    = redir_tgt;
          bubble  = 1'b1;
          state_d = S_FETCH;
        end else if (!hold) begin
          instr_d = buf_q;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end
      end
      S_DISCARD: begin
        // The in-flight response is never used; its arrival just frees the port.
        if (redirect_en) begin
          pc_d   = redir_tgt;
          bubble = 1'b1;
        end else if (!hold) begin
          bubble = 1'b1;
        end
        if (imem_valid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (bubble) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      stale_q <= '0;
      buf_q   <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      stale_q <= stale_d;
      buf_q   <= buf_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req       = rst_n & (state_q != S_BUFFERED);
  assign imem_addr      = (state_q == S_DISCARD) ? stale_q : pc_q;
  assign PC             = pc_q;
  assign IF_ID_Instr    = instr_q;
  assign IF_ID_PC_plus4 = pc4_q;
  assign IF_ID_Valid    = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by random hold/redirect/
// latency traffic, all compared against a transaction-level fetch model.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        HoldPC, IF_ID_Hold_Data, redirect_en, imem_valid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, IF_ID_Valid;
  logic [31:0] imem_addr, PC, IF_ID_Instr, IF_ID_PC_plus4;

  int n_checks = 0;
  int n_errors = 0;

  // Model: current PC, IF/ID contents, a possibly stale request still in flight,
  // and a captured word waiting for the hold to lift.
  logic [31:0] m_pc, m_stale, m_buf, m_instr, m_pc4;
  bit          m_valid, m_stale_pend, m_buf_full;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .HoldPC(HoldPC), .IF_ID_Hold_Data(IF_ID_Hold_Data),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .PC(PC), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC_plus4(IF_ID_PC_plus4),
    .IF_ID_Valid(IF_ID_Valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0001;
      32'h4:   return 32'h2009_0002;
      32'h8:   return 32'h200A_0003;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_stale = 32'h0; m_buf = 32'h0;
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    m_stale_pend = 1'b0; m_buf_full = 1'b0;
  endtask

  task automatic bubble();
    m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] w);
    m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
  endtask

  function automatic bit exp_req();
    return rst_n && !m_buf_full;
  endfunction

  function automatic logic [31:0] exp_addr();
    return m_stale_pend ? m_stale : m_pc;
  endfunction

  task automatic compare_all(input string ph);
    check({ph, ".req"}, {31'b0, imem_req}, {31'b0, exp_req()});
    if (exp_req()) check({ph, ".addr"}, imem_addr, exp_addr());
    check({ph, ".pc"}, PC, m_pc);
    check({ph, ".instr"}, IF_ID_Instr, m_instr);
    check({ph, ".pc4"}, IF_ID_PC_plus4, m_pc4);
    check({ph, ".valid"}, {31'b0, IF_ID_Valid}, {31'b0, m_valid});
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic cycle(input bit hpc, input bit hid, input bit redir,
                       input logic [31:0] rpc, input bit vld, input string ph);
    bit          v, hold;
    logic [31:0] data, tgt;
    v    = vld && exp_req();
    data = mem_word(exp_addr());
    hold = hpc | hid;
    tgt  = {rpc[31:2], 2'b00};
    HoldPC = hpc; IF_ID_Hold_Data = hid; redirect_en = redir; redirect_pc = rpc;
    imem_valid = v;
    imem_rdata = v ? data : $urandom;
    if (m_buf_full) begin
      if (redir) begin m_pc = tgt; m_buf_full = 1'b0; bubble(); end
      else if (!hold) begin deliver(m_buf); m_buf_full = 1'b0; end
    end else if (m_stale_pend) begin
      if (redir) begin m_pc = tgt; bubble(); end
      else if (!hold) bubble();
      if (v) m_stale_pend = 1'b0;
    end else begin
      if (redir) begin
        if (!v) begin m_stale = m_pc; m_stale_pend = 1'b1; end
        m_pc = tgt; bubble();
      end else if (hold) begin
        if (v) begin m_buf = data; m_buf_full = 1'b1; end
      end else if (v) deliver(data);
      else bubble();
    end
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  initial begin
    HoldPC = 0; IF_ID_Hold_Data = 0; redirect_en = 0; redirect_pc = 0;
    imem_valid = 0; imem_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;
    #1;
    compare_all("release");

    cycle(0, 0, 0, 0, 1, "zw0");
    check("zw0.word", IF_ID_Instr, 32'h2008_0001);
    cycle(0, 0, 0, 0, 1, "zw1");
    check("zw1.pc4", IF_ID_PC_plus4, 32'h8);
    cycle(0, 0, 0, 0, 1, "zw2");
    check("zw2.word", IF_ID_Instr, 32'h200A_0003);
    check("zw2.pc4", IF_ID_PC_plus4, 32'hC);

    cycle(0, 0, 0, 0, 0, "ws0");
    check("ws0.addr", imem_addr, 32'hC);
    check("ws0.valid", {31'b0, IF_ID_Valid}, 32'h0);
    cycle(0, 0, 0, 0, 0, "ws1");
    check("ws1.pc", PC, 32'hC);
    cycle(0, 0, 0, 0, 1, "ws2");
    check("ws2.pc", PC, 32'h10);

    cycle(1, 1, 0, 0, 1, "hold");
    check("hold.req", {31'b0, imem_req}, 32'h0);
    check("hold.pc4", IF_ID_PC_plus4, 32'h10);
    cycle(0, 0, 0, 0, 0, "unhold");
    check("unhold.word", IF_ID_Instr, mem_word(32'h10));
    check("unhold.pc4", IF_ID_PC_plus4, 32'h14);
    check("unhold.addr", imem_addr, 32'h14);

    cycle(0, 0, 1, 32'h40, 0, "rmiss0");
    check("rmiss0.addr", imem_addr, 32'h14);
    cycle(0, 0, 0, 0, 0, "rmiss1");
    check("rmiss1.addr", imem_addr, 32'h14);
    cycle(0, 0, 0, 0, 1, "rmiss2");
    check("rmiss2.valid", {31'b0, IF_ID_Valid}, 32'h0);
    check("rmiss2.addr", imem_addr, 32'h40);

    cycle(1, 1, 1, 32'h80, 0, "rhold");
    check("rhold.pc", PC, 32'h80);
    check("rhold.valid", {31'b0, IF_ID_Valid}, 32'h0);

    // Asynchronous reset in the middle of the discard window.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.req", {31'b0, imem_req}, 32'h0);
    check("arst.pc", PC, 32'h0);
    check("arst.valid", {31'b0, IF_ID_Valid}, 32'h0);
    model_reset();
    HoldPC = 0; IF_ID_Hold_Data = 0; redirect_en = 0; imem_valid = 0;
    @(posedge clk);
    #1;
    compare_all("arst_hold");
    rst_n = 1'b1;
    #1;
    check("arst_rel.req", {31'b0, imem_req}, 32'h1);
    check("arst_rel.addr", imem_addr, 32'h0);

    cycle(0, 0, 1, 32'hFFFF_FFFF, 1, "wrap0");
    check("wrap0.pc", PC, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 1, "wrap1");
    check("wrap1.pc4", IF_ID_PC_plus4, 32'h0);
    check("wrap1.addr", imem_addr, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 1) == 1, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS32 pipeline: owns the PC, the instruction-memory request and the IF/ID pipeline register.
- Consumes HoldPC / IF_ID_Hold_Data from the load-use hazard unit.
- Consumes branch/jump redirects from later stages.
- Feeds the decode stage, whose RS/RT fields go back to the hazard unit.
- Tolerates variable-latency instruction memory: one outstanding request, plus a one-entry buffer for responses that arrive while held.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- HoldPC  in  1  hazard-unit stall; freeze PC.
- IF_ID_Hold_Data  in  1  hazard-unit stall; freeze IF/ID register.
- redirect_en  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 until imem_valid.
- imem_valid  in  1  response valid; may be asserted in the same cycle as the request (zero wait).
- imem_rdata  in  INSTR_W  instruction returned by memory.
- PC  out  32  current fetch PC.
- IF_ID_Instr  out  INSTR_W  decode-stage instruction.
- IF_ID_PC_plus4  out  32  PC+4 of IF_ID_Instr.
- IF_ID_Valid  out  1  IF_ID_Instr is a real instruction.

Behaviour:
- hold = HoldPC | IF_ID_Hold_Data.
- Priority, highest first: reset > redirect_en > hold > normal.
- Bubble = IF_ID_Instr<=0 (sll $0 NOP), IF_ID_PC_plus4<=0, IF_ID_Valid<=0.
- Reset (rst_n low, asynchronous):
  - PC=RESET_PC.
  - IF/ID register = bubble values.
  - Buffer empty.
  - State=FETCH.
  - imem_req forced 0 while rst_n is low.
- PC+4 wraps modulo 2^32; 32'hFFFF_FFFC advances to 0.
- FSM state FETCH: imem_req=1, imem_addr=PC.
  - redirect:
    - PC<=redirect_pc, IF/ID<=bubble.
    - imem_valid=1: the response is dropped; stay in FETCH.
    - imem_valid=0: stale_addr<=PC, go to DISCARD.
  - hold & imem_valid:
    - buf_instr<=imem_rdata.
    - PC and IF/ID unchanged.
    - Go to BUFFERED.
  - hold & !imem_valid: everything holds.
  - !hold & imem_valid:
    - IF_ID_Instr<=imem_rdata, IF_ID_PC_plus4<=PC+4, IF_ID_Valid<=1.
    - PC<=PC+4.
  - !hold & !imem_valid: IF/ID<=bubble; PC holds.
- FSM state BUFFERED: imem_req=0.
  - redirect: PC<=redirect_pc, buffer discarded, IF/ID<=bubble, go to FETCH.
  - hold: everything holds.
  - else: IF/ID<={buf_instr, PC+4, 1}, PC<=PC+4, go to FETCH.
- FSM state DISCARD: imem_req=1, imem_addr=stale_addr (the address must stay stable for the outstanding request).
  - IF/ID<=bubble unless hold, in which case IF/ID holds. Redirect still forces a bubble.
  - redirect: PC<=redirect_pc, remain in DISCARD.
  - imem_valid: response dropped, go to FETCH (the fetch at PC starts next cycle).
- Simultaneous redirect and hold: redirect wins. The IF/ID content is killed and the PC is updated even though HoldPC=1.
- Exactly one request is outstanding at any time. imem_addr never changes while imem_req=1 and imem_valid=0.
- No combinational path from imem_rdata to any output; IF/ID outputs are registered only.

Test Plan:
- Zero-wait fetch:
  - Stimulus: release reset, memory returns 0x20080001, 0x20090002, 0x200A0003 at 0x0, 0x4, 0x8 with imem_valid=1.
  - Response: IF_ID_Instr shows those three values on consecutive cycles; IF_ID_PC_plus4 = 4, 8, 12; IF_ID_Valid=1.
- Wait states:
  - Stimulus: the response for 0x4 arrives 2 cycles late.
  - Response: two bubbles (IF_ID_Valid=0, IF_ID_Instr=0); imem_addr stays 0x4; PC advances to 0x8 only on the valid cycle.
- Load-use hold:
  - Stimulus: HoldPC=IF_ID_Hold_Data=1 for 1 cycle while the response for 0x8 arrives.
  - Response: IF/ID unchanged; state BUFFERED; imem_req=0. The cycle after hold drops: IF_ID_Instr=buffered word, IF_ID_PC_plus4=0xC, next imem_addr=0xC.
- Redirect during a miss:
  - Stimulus: redirect_en with redirect_pc=0x40 while 0x10 is outstanding.
  - Response: imem_addr stays 0x10 until imem_valid; that response is dropped (IF_ID_Valid=0); the next request address is 0x40.
- Redirect plus hold in the same cycle:
  - Stimulus: redirect_pc=0x80 with HoldPC=IF_ID_Hold_Data=1.
  - Response: IF_ID_Valid=0 next cycle; PC=0x80.
- Async reset:
  - Stimulus: rst_n low mid-DISCARD.
  - Response: imem_req drops immediately; PC=RESET_PC; IF_ID_Valid=0. After release, the first request is to RESET_PC.
- PC wrap:
  - Stimulus: redirect to 0xFFFFFFFC, then a valid response.
  - Response: IF_ID_PC_plus4=0; next imem_addr=0.
